uart_xmt: RTL and testbench

UART transmitter paired with the team's 4x-oversampled UART receiver: accepts bytes over a valid/ready handshake, buffers them in a small FIFO and serialises each one onto `txd`. Each frame is 1 start bit (0), 8 data bits MSB first, and 1 stop bit (1), so the receiver's left-shift register reassembles the byte unchanged. The block sits between the core's I/O store path and the board TX pin, in the same `clk` domain as the receiver.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_xmt_fifo.sv | 58 +++++
 rtl/uart_xmt.sv | 119 +++++++++++
 tb/tb_uart_xmt.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_xmt_fifo.sv
// Synchronous FIFO buffering bytes between the producer and the transmit FSM.
module uart_xmt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCnt = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_xmt.sv
// UART transmitter: 8N1 frames, MSB first, fed from a small FIFO.
module uart_xmt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_OVERSAMPLE,
  parameter int unsigned DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  uart_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q;
  logic          pop, bit_end;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  uart_xmt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end  = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign tx_ready = !fifo_full;
  assign txd      = txd_q;
  assign busy     = busy_q;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    timer_d   = bit_end ? '0 : timer_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = 3'(UART_DATA_BITS - 1);
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_idx_d = bit_idx_q - 1'b1;
          if (bit_idx_q == 3'd0) state_d = StStop;
        end
      end
      StStop: begin
        // Chaining straight into the next start bit keeps bursts gap-free.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_q)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_q[7];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= (state_q != StIdle) || (fifo_count != '0);
    end
  end

endmodule

// File: tb/tb_uart_xmt.sv
// Self-checking bench for uart_xmt: frame vectors, burst, full-FIFO, reset and wrap sequences.
module tb_uart_xmt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, txd, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames_seen = 0;

  logic [7:0] exp_q[$];
  int         frame_starts[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // txd bits in time order, start bit in [9]
  } vec_t;
  vec_t vecs[5];

  uart_xmt #(
    .CLKS_PER_BIT (4),
    .DEPTH        (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: captures 40 samples per frame and scores the decoded byte.
  logic mon_s [40];
  bit   mon_active = 1'b0;
  int   mon_off = 0;
  always @(negedge clk) begin : monitor
    int bad;
    logic [7:0] b;
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && txd === 1'b0) begin
        mon_active = 1'b1;
        mon_off = 0;
        frame_starts.push_back(cyc);
      end
      if (mon_active) begin
        mon_s[mon_off] = txd;
        mon_off++;
        if (mon_off == 40) begin
          mon_active = 1'b0;
          bad = 0;
          for (int k = 0; k < 10; k++)
            for (int c = 1; c < 4; c++)
              if (mon_s[4*k+c] !== mon_s[4*k]) bad++;
          check("bit_hold", bad, 0);
          check("stop_bit", {31'd0, mon_s[36]}, 1);
          for (int k = 0; k < 8; k++) b[7-k] = mon_s[4*(k+1)];
          frames_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got %0h expected none", b);
          end else begin
            check("frame_data", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // Leaves tx_valid high; returns at accept edge + #1.
  task automatic push_byte(input logic [7:0] d, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int w = 0; w < 200; w++) begin
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", {31'd0, ok}, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (ok) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    check("idle_timeout", {31'd0, ok}, 1);
  endtask

  task automatic check_contiguous(input int n);
    check("frame_count", frame_starts.size(), n);
    for (int i = 1; i < frame_starts.size(); i++)
      check("frame_gap", frame_starts[i] - frame_starts[i-1], 40);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int acc[6];
    int a0, k, n0, low_cnt, busy_cnt, fs0;
    bit seen;

    vecs[0] = '{data: 8'hA5, frame: 10'b0_10100101_1};
    vecs[1] = '{data: 8'h00, frame: 10'b0_00000000_1};
    vecs[2] = '{data: 8'hFF, frame: 10'b0_11111111_1};
    vecs[3] = '{data: 8'h3C, frame: 10'b0_00111100_1};
    vecs[4] = '{data: 8'h81, frame: 10'b0_10000001_1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", {31'd0, txd}, 1);
    check("rst_ready", {31'd0, tx_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;

    // Single frames from idle: latency and every bit cycle against the table.
    for (int v = 0; v < 5; v++) begin
      wait_idle(100);
      push_byte(vecs[v].data, a0);
      tx_valid = 1'b0;
      @(posedge clk);
      #1;
      check("latency_n1", {31'd0, txd}, 1);
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 4; c++) begin
          @(posedge clk);
          #1;
          check("frame_bit", {31'd0, txd}, {31'd0, vecs[v].frame[9-b]});
        end
      end
      check("busy_stop", {31'd0, busy}, 1);
      @(posedge clk);
      #1;
      check("busy_fall", {31'd0, busy}, 0);
    end

    // Burst 0x01..0x06 with tx_valid held.
    wait_idle(100);
    frame_starts.delete();
    for (int i = 0; i < 5; i++) push_byte(8'(i + 1), acc[i]);
    @(negedge clk);
    check("ready_drop", {31'd0, tx_ready}, 0);
    push_byte(8'h06, acc[5]);
    tx_valid = 1'b0;
    for (int i = 1; i < 5; i++) check("burst_accept_gap", acc[i] - acc[i-1], 1);
    // First frame's pop edge is 37 edges after the 5th accept; accept follows one edge later.
    check("burst_sixth_gap", acc[5] - acc[4], 38);
    wait_idle(400);
    check_contiguous(6);
    check("burst_drained", exp_q.size(), 0);

    // Push held while full: the pop edge must not also accept the byte.
    frame_starts.delete();
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i), acc[i]);
    @(negedge clk);
    tx_data = 8'hEE;
    seen = 1'b0;
    for (k = 0; k < 45; k++) begin
      if (tx_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("full_ready_seen", {31'd0, seen}, 1);
    check("full_refuse_wait", k, 37);
    wait_idle(400);
    check_contiguous(5);
    check("full_drained", exp_q.size(), 0);

    // Reset mid-DATA of 0x3C with two bytes queued.
    wait_idle(100);
    push_byte(8'h3C, a0);
    push_byte(8'h11, a0);
    push_byte(8'h22, a0);
    tx_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_txd", {31'd0, txd}, 1);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_ready", {31'd0, tx_ready}, 1);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n0 = frame_starts.size();
    fs0 = frames_seen;
    low_cnt = 0;
    busy_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
      if (busy !== 1'b0) busy_cnt++;
    end
    check("postrst_txd_low", low_cnt, 0);
    check("postrst_busy", busy_cnt, 0);
    check("postrst_frames", frame_starts.size() - n0 + frames_seen - fs0, 0);

    // Wrap-around: 3*DEPTH+1 bytes with irregular gaps.
    fs0 = frames_seen;
    for (int i = 0; i < 13; i++) begin
      k = int'($urandom_range(0, 3));
      if (k > 0) begin
        tx_valid = 1'b0;
        repeat (k) @(negedge clk);
      end
      push_byte(8'($urandom_range(0, 255)), a0);
    end
    tx_valid = 1'b0;
    wait_idle(13 * 45 + 200);
    check("wrap_frames", frames_seen - fs0, 13);
    check("wrap_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
